// File: rtl/encoder_arbiter.sv
// Round-robin 16-way arbiter with a bounded grant hold time.
// One idle cycle always separates consecutive grants.
module encoder_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] req,
    input  logic        release_grant,
    output logic        grant_valid,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic        timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ptr;
    logic [3:0]  ptr_nxt;
    logic [3:0]  idx;
    logic [3:0]  idx_nxt;
    logic [3:0]  win;
    logic [7:0]  hcnt;
    logic [7:0]  hcnt_nxt;
    logic        tmo_nxt;
    logic        hold_hit;
    logic        exit_now;

    assign hold_hit = (hcnt == 8'(HOLD_MAX));
    assign exit_now = release_grant | ~req[idx] | ~enable | hold_hit;

    // Scan downward so the lowest offset from ptr is the last to win.
    always_comb begin
        win = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[ptr + 4'(i)]) begin
                win = ptr + 4'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        hcnt_nxt  = hcnt;
        tmo_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && (req != 16'h0000)) begin
                    state_nxt = GRANT;
                    idx_nxt   = win;
                    hcnt_nxt  = 8'd1;
                end
            end
            GRANT: begin
                if (exit_now) begin
                    state_nxt = IDLE;
                    idx_nxt   = 4'd0;
                    ptr_nxt   = idx + 4'd1;
                    hcnt_nxt  = 8'd0;
                    tmo_nxt   = hold_hit & ~release_grant
                              & req[idx] & enable;
                end else if (hcnt != 8'hFF) begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 4'd0;
            idx     <= 4'd0;
            hcnt    <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            hcnt    <= hcnt_nxt;
            timeout <= tmo_nxt;
        end
    end

    assign grant_valid  = (state == GRANT);
    assign grant_idx    = idx;
    assign grant_onehot = grant_valid ? (16'd1 << idx) : 16'h0000;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Directed-vector bench for encoder_arbiter with HOLD_MAX=4.
// Expected values are hand-derived from the arbitration rules.
module tb_encoder_arbiter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] req;
    logic        release_grant;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        timeout;

    int n_cmp;
    int n_bad;

    encoder_arbiter #(.HOLD_MAX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req          (req),
        .release_grant(release_grant),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] i);
        check({tag, ".gv"}, 32'(grant_valid), 32'd1);
        check({tag, ".idx"}, 32'(grant_idx), 32'(i));
        check({tag, ".oh"}, 32'(grant_onehot), 32'(16'd1 << i));
    endtask

    task automatic chk_idle(input string tag, input logic tmo);
        check({tag, ".gv"}, 32'(grant_valid), 32'd0);
        check({tag, ".idx"}, 32'(grant_idx), 32'd0);
        check({tag, ".oh"}, 32'(grant_onehot), 32'd0);
        check({tag, ".tmo"}, 32'(timeout), 32'(tmo));
    endtask

    logic [3:0] seq [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        req = 16'h0000;
        release_grant = 1'b0;
        #1;
        chk_idle("reset", 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // single requester, release after one cycle
        enable = 1'b1;
        req = 16'h0004;
        step();
        chk_grant("g2", 4'd2);
        release_grant = 1'b1;
        step();
        chk_idle("g2.rel", 1'b0);

        // alternating grants from ptr=3
        req = 16'h1040;
        seq[0] = 4'd6;
        seq[1] = 4'd12;
        seq[2] = 4'd6;
        seq[3] = 4'd12;
        for (int k = 0; k < 4; k++) begin
            release_grant = 1'b0;
            step();
            chk_grant($sformatf("rr%0d", k), seq[k]);
            release_grant = 1'b1;
            step();
            chk_idle($sformatf("rr%0d.idle", k), 1'b0);
        end

        // disabled: nothing granted, then grant at ptr=13
        release_grant = 1'b0;
        enable = 1'b0;
        req = 16'hFFFF;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("dis%0d", k), 32'(grant_valid), 32'd0);
        end
        enable = 1'b1;
        step();
        chk_grant("en", 4'd13);
        release_grant = 1'b1;
        step();
        chk_idle("en.rel", 1'b0);

        // ptr=14: grant 12 by wrap, then drop req
        release_grant = 1'b0;
        req = 16'h1000;
        step();
        chk_grant("wrap12", 4'd12);
        req = 16'h0000;
        step();
        chk_idle("drop", 1'b0);
        req = 16'hFFFF;
        step();
        chk_grant("ptr13", 4'd13);
        release_grant = 1'b1;
        step();
        chk_idle("ptr13.rel", 1'b0);

        // hold limit: 4 grant cycles, timeout, re-grant
        release_grant = 1'b0;
        req = 16'h0400;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant($sformatf("hold%0d", k), 4'd10);
            check($sformatf("hold%0d.tmo", k), 32'(timeout), 32'd0);
        end
        step();
        chk_idle("tmo", 1'b1);
        step();
        chk_grant("regrant", 4'd10);
        check("regrant.tmo", 32'(timeout), 32'd0);
        step();
        step();
        step();
        release_grant = 1'b1;
        step();
        chk_idle("rel_at_max", 1'b0);

        // async reset mid-grant
        release_grant = 1'b0;
        req = 16'h0040;
        step();
        chk_grant("pre_rst", 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 1'b0);
        step();
        chk_idle("in_rst", 1'b0);
        rst_n = 1'b1;
        req = 16'h0041;
        step();
        chk_grant("post_rst", 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
